// File: rtl/game_controller_if.sv
// Player/playfield bus between the game sequencer and its environment.
// The slave side is the controller; the master side drives buttons and positions.
interface game_controller_if;
  logic        btn_flap;
  logic        btn_pause;
  logic [15:0] birdY;
  logic [15:0] pipe_x;
  logic [15:0] gap_y;
  logic [3:0]  game_state;
  logic        flap;
  logic        collision;
  logic [11:0] score;

  modport master (
    output btn_flap, btn_pause, birdY, pipe_x, gap_y,
    input  game_state, flap, collision, score
  );

  modport slave (
    input  btn_flap, btn_pause, birdY, pipe_x, gap_y,
    output game_state, flap, collision, score
  );
endinterface

// File: rtl/game_controller.sv
// Top-level game sequencer: one-hot game state, flap pulse generation,
// bird collision detection and a saturating 3-digit BCD score.
module game_controller #(
  parameter int BIRD_X      = 160,
  parameter int BIRD_SIZE_X = 34,
  parameter int BIRD_SIZE_Y = 24,
  parameter int PIPE_WIDTH  = 52,
  parameter int GAP_SIZE    = 120,
  parameter int SCREEN_H    = 480,
  parameter int END_HOLD    = 90
) (
  input  logic             GAME_clk,
  input  logic             rst,
  game_controller_if.slave bus
);

  typedef enum logic [3:0] {
    ST_START = 4'b0001,
    ST_GAME  = 4'b0010,
    ST_PAUSE = 4'b0100,
    ST_END   = 4'b1000
  } state_t;

  localparam int HOLD_W = $clog2(END_HOLD + 1);

  localparam logic signed [16:0] SZ_Y     = 17'(BIRD_SIZE_Y);
  localparam logic signed [16:0] SCR_H    = 17'(SCREEN_H);
  localparam logic signed [16:0] GAP_H    = 17'(GAP_SIZE);
  localparam logic        [16:0] BIRD_L   = 17'(BIRD_X);
  localparam logic        [16:0] BIRD_R   = 17'(BIRD_X + BIRD_SIZE_X);
  localparam logic        [16:0] PIPE_W   = 17'(PIPE_WIDTH);

  // BCD +1 with carry between digits, saturating at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h999) begin
      r = v;
    end else if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  state_t            r_state, w_state_nxt;
  logic              r_flap, w_flap_nxt;
  logic              r_collision, w_collision_nxt;
  logic [11:0]       r_score, w_score_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              r_passed_q, w_passed_q_nxt;
  logic              r_btn_flap_q, r_btn_pause_q;

  logic              w_flap_rise, w_pause_rise;
  logic signed [16:0] w_by, w_by_bot, w_gap_top, w_gap_bot;
  logic        [16:0] w_px, w_px_r;
  logic              w_bounds_hit, w_x_overlap, w_y_out, w_hit, w_passed;

  assign w_flap_rise  = bus.btn_flap  & ~r_btn_flap_q;
  assign w_pause_rise = bus.btn_pause & ~r_btn_pause_q;

  // birdY is signed so a bird flying off the top reads as negative
  assign w_by      = {bus.birdY[15], bus.birdY};
  assign w_by_bot  = w_by + SZ_Y;
  assign w_gap_top = $signed({1'b0, bus.gap_y});
  assign w_gap_bot = w_gap_top + GAP_H;
  assign w_px      = {1'b0, bus.pipe_x};
  assign w_px_r    = w_px + PIPE_W;

  assign w_bounds_hit = (w_by < 17'sd0) | (w_by_bot > SCR_H);
  assign w_x_overlap  = (w_px < BIRD_R) & (w_px_r > BIRD_L);
  assign w_y_out      = (w_by < w_gap_top) | (w_by_bot > w_gap_bot);
  assign w_hit        = w_bounds_hit | (w_x_overlap & w_y_out);
  assign w_passed     = (w_px_r < BIRD_L);

  // Next-state and next-output logic for the game sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_flap_nxt      = 1'b0;
    w_collision_nxt = 1'b0;
    w_score_nxt     = r_score;
    w_hold_nxt      = r_hold;
    w_passed_q_nxt  = w_passed;
    case (r_state)
      ST_START: begin
        if (w_flap_rise) begin
          w_state_nxt    = ST_GAME;
          w_flap_nxt     = 1'b1;
          w_score_nxt    = 12'h000;
          w_passed_q_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_GAME: begin
        if (w_hit) begin
          w_state_nxt     = ST_END;
          w_collision_nxt = 1'b1;
          w_hold_nxt      = HOLD_W'(END_HOLD);
        end else begin
          if (w_pause_rise) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_flap_rise) begin
            w_flap_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_GAME;
          end
          // Rising edge of passed so a pipe scores once until it wraps around
          if (w_passed && !r_passed_q) begin
            w_score_nxt = bcd_inc(r_score);
          end else begin
            w_score_nxt = r_score;
          end
        end
      end
      ST_PAUSE: begin
        if (w_pause_rise) begin
          w_state_nxt = ST_GAME;
        end else begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_END: begin
        if (r_hold != {HOLD_W{1'b0}}) begin
          w_hold_nxt = r_hold - HOLD_W'(1);
        end else if (w_flap_rise) begin
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_END;
        end
      end
      default: begin
        w_state_nxt = ST_START;
      end
    endcase
  end

  // State, output and edge-detect registers.
  always_ff @(posedge GAME_clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_START;
      r_flap        <= 1'b0;
      r_collision   <= 1'b0;
      r_score       <= 12'h000;
      r_hold        <= {HOLD_W{1'b0}};
      r_passed_q    <= 1'b0;
      r_btn_flap_q  <= 1'b0;
      r_btn_pause_q <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_flap        <= w_flap_nxt;
      r_collision   <= w_collision_nxt;
      r_score       <= w_score_nxt;
      r_hold        <= w_hold_nxt;
      r_passed_q    <= w_passed_q_nxt;
      r_btn_flap_q  <= bus.btn_flap;
      r_btn_pause_q <= bus.btn_pause;
    end
  end

  assign bus.game_state = r_state;
  assign bus.flap       = r_flap;
  assign bus.collision  = r_collision;
  assign bus.score      = r_score;

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller.
module tb_game_controller;
  localparam int END_HOLD = 90;

  logic GAME_clk = 1'b0;
  logic rst      = 1'b1;
  int   n_pass   = 0;
  int   n_total  = 0;

  game_controller_if bus();

  game_controller #(.END_HOLD(END_HOLD)) dut (
    .GAME_clk (GAME_clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 GAME_clk = ~GAME_clk;

  task automatic step();
    @(posedge GAME_clk);
    #1;
  endtask

  // Brings the DUT into IN_GAME with a safe bird and an off-screen pipe.
  task automatic go_in_game();
    bus.btn_flap = 1'b0; bus.btn_pause = 1'b0;
    bus.birdY = 16'd228; bus.pipe_x = 16'd640; bus.gap_y = 16'd200;
    step();
    if (bus.game_state == 4'b1000) begin
      repeat (END_HOLD + 5) step();
      bus.btn_flap = 1'b1; step(); bus.btn_flap = 1'b0; step();
    end
    if (bus.game_state == 4'b0100) begin
      bus.btn_pause = 1'b1; step(); bus.btn_pause = 1'b0; step();
    end
    if (bus.game_state == 4'b0001) begin
      bus.btn_flap = 1'b1; step(); bus.btn_flap = 1'b0; step();
    end
  endtask

  task automatic do_pass(input int n);
    repeat (n) begin
      bus.pipe_x = 16'd100; step();
      bus.pipe_x = 16'd640; step();
    end
  endtask

  task automatic test_reset();
    bus.btn_flap = 1'b0; bus.btn_pause = 1'b0;
    bus.birdY = 16'd228; bus.pipe_x = 16'd640; bus.gap_y = 16'd200;
    rst = 1'b1;
    step(); step();
    n_total++; if (bus.game_state !== 4'b0001) $display("FAIL reset_state: got %b expected 0001", bus.game_state); else n_pass++;
    n_total++; if (bus.flap !== 1'b0) $display("FAIL reset_flap: got %b expected 0", bus.flap); else n_pass++;
    n_total++; if (bus.collision !== 1'b0) $display("FAIL reset_collision: got %b expected 0", bus.collision); else n_pass++;
    n_total++; if (bus.score !== 12'h000) $display("FAIL reset_score: got %h expected 000", bus.score); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_start_flap();
    int pulses;
    step();
    n_total++; if (bus.game_state !== 4'b0001) $display("FAIL start_idle: got %b expected 0001", bus.game_state); else n_pass++;
    bus.btn_flap = 1'b1;
    step();
    n_total++; if (bus.game_state !== 4'b0010) $display("FAIL start_state: got %b expected 0010", bus.game_state); else n_pass++;
    n_total++; if (bus.flap !== 1'b1) $display("FAIL start_flap: got %b expected 1", bus.flap); else n_pass++;
    n_total++; if (bus.score !== 12'h000) $display("FAIL start_score: got %h expected 000", bus.score); else n_pass++;
    pulses = 0;
    repeat (10) begin
      step();
      if (bus.flap) pulses++;
    end
    n_total++; if (pulses !== 0) $display("FAIL held_flap_pulses: got %0d expected 0", pulses); else n_pass++;
    bus.btn_flap = 1'b0;
    step();
    bus.btn_flap = 1'b1;
    step();
    n_total++; if (bus.flap !== 1'b1) $display("FAIL ingame_flap: got %b expected 1", bus.flap); else n_pass++;
    bus.btn_flap = 1'b0;
    step();
  endtask

  task automatic test_bounds();
    bus.birdY = 16'hFFFE;
    step();
    n_total++; if (bus.game_state !== 4'b1000) $display("FAIL top_bound_state: got %b expected 1000", bus.game_state); else n_pass++;
    n_total++; if (bus.collision !== 1'b1) $display("FAIL top_bound_collision: got %b expected 1", bus.collision); else n_pass++;
    bus.birdY = 16'd228;
    step();
    n_total++; if (bus.collision !== 1'b0) $display("FAIL collision_width: got %b expected 0", bus.collision); else n_pass++;
    go_in_game();
    bus.birdY = 16'd456;
    step();
    n_total++; if (bus.game_state !== 4'b0010) $display("FAIL bottom_edge_ok: got %b expected 0010", bus.game_state); else n_pass++;
    bus.birdY = 16'd457;
    step();
    n_total++; if (bus.game_state !== 4'b1000) $display("FAIL bottom_bound_state: got %b expected 1000", bus.game_state); else n_pass++;
    go_in_game();
  endtask

  task automatic test_pipe_hit();
    bus.pipe_x = 16'd150; bus.gap_y = 16'd200; bus.birdY = 16'd250;
    step();
    n_total++; if (bus.game_state !== 4'b0010) $display("FAIL in_gap_state: got %b expected 0010", bus.game_state); else n_pass++;
    bus.birdY = 16'd180;
    step();
    n_total++; if (bus.game_state !== 4'b1000) $display("FAIL pipe_hit_state: got %b expected 1000", bus.game_state); else n_pass++;
    n_total++; if (bus.collision !== 1'b1) $display("FAIL pipe_hit_collision: got %b expected 1", bus.collision); else n_pass++;
    go_in_game();
  endtask

  task automatic test_score();
    logic [11:0] exp_score [3];
    exp_score[0] = 12'h001; exp_score[1] = 12'h002; exp_score[2] = 12'h003;
    n_total++; if (bus.score !== 12'h000) $display("FAIL score_cleared: got %h expected 000", bus.score); else n_pass++;
    for (int p = 0; p < 3; p++) begin
      bus.pipe_x = 16'd200; step();
      bus.pipe_x = 16'd150; step();
      bus.pipe_x = 16'd100; step();
      bus.pipe_x = 16'd640; step();
      n_total++; if (bus.score !== exp_score[p]) $display("FAIL sweep_score_%0d: got %h expected %h", p, bus.score, exp_score[p]); else n_pass++;
    end
    n_total++; if (bus.game_state !== 4'b0010) $display("FAIL sweep_state: got %b expected 0010", bus.game_state); else n_pass++;
    do_pass(7);
    n_total++; if (bus.score !== 12'h010) $display("FAIL score_carry_tens: got %h expected 010", bus.score); else n_pass++;
    do_pass(89);
    n_total++; if (bus.score !== 12'h099) $display("FAIL score_099: got %h expected 099", bus.score); else n_pass++;
    do_pass(1);
    n_total++; if (bus.score !== 12'h100) $display("FAIL score_carry_hundreds: got %h expected 100", bus.score); else n_pass++;
    do_pass(899);
    n_total++; if (bus.score !== 12'h999) $display("FAIL score_999: got %h expected 999", bus.score); else n_pass++;
    do_pass(1);
    n_total++; if (bus.score !== 12'h999) $display("FAIL score_saturate: got %h expected 999", bus.score); else n_pass++;
  endtask

  task automatic test_pause();
    bus.btn_pause = 1'b1; bus.btn_flap = 1'b1;
    step();
    n_total++; if (bus.game_state !== 4'b0100) $display("FAIL pause_state: got %b expected 0100", bus.game_state); else n_pass++;
    n_total++; if (bus.flap !== 1'b0) $display("FAIL pause_flap: got %b expected 0", bus.flap); else n_pass++;
    bus.btn_pause = 1'b0; bus.btn_flap = 1'b0;
    step();
    bus.btn_flap = 1'b1; bus.birdY = 16'hFFFB;
    step();
    n_total++; if (bus.game_state !== 4'b0100) $display("FAIL pause_hold_state: got %b expected 0100", bus.game_state); else n_pass++;
    n_total++; if (bus.flap !== 1'b0) $display("FAIL pause_hold_flap: got %b expected 0", bus.flap); else n_pass++;
    n_total++; if (bus.collision !== 1'b0) $display("FAIL pause_hold_collision: got %b expected 0", bus.collision); else n_pass++;
    n_total++; if (bus.score !== 12'h999) $display("FAIL pause_score: got %h expected 999", bus.score); else n_pass++;
    bus.btn_flap = 1'b0; bus.birdY = 16'd228;
    step();
    bus.btn_pause = 1'b1;
    step();
    n_total++; if (bus.game_state !== 4'b0010) $display("FAIL resume_state: got %b expected 0010", bus.game_state); else n_pass++;
    bus.btn_pause = 1'b0;
    step();
  endtask

  task automatic test_end_hold();
    bus.birdY = 16'hFFFE;
    step();
    n_total++; if (bus.game_state !== 4'b1000) $display("FAIL end_entry: got %b expected 1000", bus.game_state); else n_pass++;
    bus.birdY = 16'd228;
    repeat (9) step();
    bus.btn_flap = 1'b1;
    step();
    n_total++; if (bus.game_state !== 4'b1000) $display("FAIL end_early_flap: got %b expected 1000", bus.game_state); else n_pass++;
    n_total++; if (bus.score !== 12'h999) $display("FAIL end_score_held: got %h expected 999", bus.score); else n_pass++;
    bus.btn_flap = 1'b0;
    step();
    repeat (END_HOLD) step();
    bus.btn_flap = 1'b1;
    step();
    n_total++; if (bus.game_state !== 4'b0001) $display("FAIL end_restart: got %b expected 0001", bus.game_state); else n_pass++;
    n_total++; if (bus.flap !== 1'b0) $display("FAIL end_restart_flap: got %b expected 0", bus.flap); else n_pass++;
    bus.btn_flap = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_game();
    go_in_game();
    do_pass(5);
    n_total++; if (bus.score !== 12'h005) $display("FAIL mid_score: got %h expected 005", bus.score); else n_pass++;
    bus.btn_flap = 1'b1;
    step();
    n_total++; if (bus.flap !== 1'b1) $display("FAIL mid_flap: got %b expected 1", bus.flap); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (bus.game_state !== 4'b0001) $display("FAIL async_rst_state: got %b expected 0001", bus.game_state); else n_pass++;
    n_total++; if (bus.score !== 12'h000) $display("FAIL async_rst_score: got %h expected 000", bus.score); else n_pass++;
    n_total++; if (bus.flap !== 1'b0) $display("FAIL async_rst_flap: got %b expected 0", bus.flap); else n_pass++;
    bus.btn_flap = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_start_flap();
    test_bounds();
    test_pipe_hit();
    test_score();
    test_pause();
    test_end_hold();
    test_reset_mid_game();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
